axi_buffer_rab_ft: RTL and testbench
====================================

# axi_buffer_rab_ft

Parametrised successor to the RAB AXI channel buffer: a valid/ready FIFO of configurable width and any depth ≥ 2, power of two or not. It adds an optional zero-latency fall-through mode, a synchronous flush, a fill-level output and programmable almost-full/almost-empty flags. One instance sits on each AXI channel (AW, W, B, AR, R) between the slave port and the RAB translation logic. Flush drains stale beats on a RAB reconfiguration.

## Interface
- DATA_WIDTH, 64, payload width in bits (≥ 1)
- BUFFER_DEPTH, 4, number of storage slots (≥ 2; non-power-of-two legal)
- FALL_THROUGH, 0, 0 = registered (1-cycle min latency); 1 = empty-buffer bypass (0-cycle latency)
- ALMOST_FULL_TH, BUFFER_DEPTH-1, almost_full asserted when fill_level ≥ this (1..BUFFER_DEPTH)
- ALMOST_EMPTY_TH, 1, almost_empty asserted when fill_level ≤ this (0..BUFFER_DEPTH-1)
- Derived: PTR_W = max(1, $clog2(BUFFER_DEPTH)); CNT_W = $clog2(BUFFER_DEPTH+1)

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of all buffered entries
- valid_in  in  1  upstream beat valid
- data_in  in  DATA_WIDTH  upstream payload
- ready_out  out  1  buffer accepts a beat this cycle
- data_out  out  DATA_WIDTH  downstream payload
- valid_out  out  1  downstream beat valid
- ready_in  in  1  downstream accepts a beat
- fill_level  out  CNT_W  number of stored entries (0..BUFFER_DEPTH)
- almost_full  out  1  fill_level ≥ ALMOST_FULL_TH
- almost_empty  out  1  fill_level ≤ ALMOST_EMPTY_TH

## Operation
- State: write pointer wr_ptr, read pointer rd_ptr (PTR_W bits each), element count cnt (CNT_W bits), storage array of BUFFER_DEPTH × DATA_WIDTH. Storage is not reset.
- The pointers wrap explicitly: when a pointer at BUFFER_DEPTH-1 is incremented, it goes to 0. There is no modulo-2^PTR_W wrap.
- full = (cnt == BUFFER_DEPTH); empty = (cnt == 0).
- ready_out = !full && !flush. There is no combinational path from ready_in to ready_out, so a full buffer refuses a push even while it is popping.
- push = valid_in && ready_out; pop = valid_out && ready_in.
- Registered mode:
  - valid_out = !empty && !flush.
  - data_out = storage[rd_ptr] when valid_out, otherwise all-zeros.
- Fall-through mode, buffer empty:
  - valid_out = valid_in && !flush; data_out = data_in (all-zeros when valid_out is low).
  - If push and pop occur together while empty, the beat bypasses storage. wr_ptr, rd_ptr and cnt are all unchanged.
- Fall-through mode, buffer not empty: behaves exactly as registered mode.
- Count update:
  - push only: cnt+1.
  - pop only: cnt−1.
  - push and pop together: cnt unchanged, wr_ptr and rd_ptr both advance.
  - Exception: a bypass (fall-through, empty) advances neither pointer.
- Ordering: beats leave strictly in acceptance order. No beat is dropped or duplicated.
- Flush:
  - While flush is high, ready_out and valid_out are forced to 0, so no transfer occurs.
  - On the next edge, wr_ptr = rd_ptr = 0 and cnt = 0. Flush held for multiple cycles keeps this state.
- fill_level = cnt. The flags are combinational from cnt only and do not depend on the current-cycle handshake.

## Timing
- Reset values (rstn low, asynchronous):
  - wr_ptr = rd_ptr = 0, cnt = 0.
  - valid_out = 0, and data_out = 0 in registered mode. In fall-through mode, valid_out and data_out still follow valid_in/data_in, gated by flush.
  - ready_out = 1 unless flush; fill_level = 0; almost_full = (ALMOST_FULL_TH == 0) → 0; almost_empty = 1.
- Reset mid-operation: all queued beats are discarded immediately. The first beat after rstn deasserts is treated as arriving to an empty buffer.
- Latency, registered mode: a beat pushed at edge N is visible with valid_out high after edge N. Minimum latency is 1 cycle.
- Latency, fall-through mode: 0 cycles when the buffer is empty; otherwise equal to queue position.
- Throughput: 1 beat/cycle sustained at any fill level below full. At full, there is 1 pop-then-push bubble.
- valid_out never deasserts without a pop or a flush. data_out is stable while valid_out is high and ready_in is low.
- Boundaries:
  - Pointer wrap at BUFFER_DEPTH-1 → 0 for non-power-of-two depths.
  - full+pop: cnt decrements and ready_out rises on the next cycle.
  - empty+push in registered mode: no same-cycle output.

## Test plan
- DEPTH=3, registered: push 0xA1, 0xA2, 0xA3 with ready_in=0 → ready_out=0 after 3rd edge, fill_level=3, almost_full=1. Then ready_in=1 for 3 cycles → data_out sequence A1, A2, A3, fill_level=0, almost_empty=1.
- DEPTH=5, registered, streaming: valid_in and ready_in held high for 40 cycles with an incrementing payload → output equals input delayed by 1 cycle, fill_level stays at 1, pointers wrap cleanly across 4→0 eight times.
- FALL_THROUGH=1, empty: valid_in=1, data_in=0x55, ready_in=1 in the same cycle → valid_out=1, data_out=0x55 the same cycle, fill_level stays 0. Repeat with ready_in=0 → 0x55 is stored and fill_level=1 next cycle.
- Full with simultaneous pop (DEPTH=4): fill to 4, then valid_in=1 and ready_in=1 → only the pop occurs, fill_level=3, and the offered beat is accepted on the following cycle.
- Flush: fill with 3 beats and assert flush for 1 cycle together with valid_in=1 → no transfer in the flush cycle, next cycle fill_level=0, valid_out=0. A new beat 0x77 then emerges first.
- Async reset mid-burst: rstn low for half a cycle at fill_level=2 → outputs take reset values immediately. After release, the first pushed beat 0x99 is the first popped beat.

Source files
------------

// File: rtl/axi_buffer_rab_ft.sv
// Valid/ready channel buffer for the RAB AXI slave path. It supports any depth of 2 or more
// and an optional zero-latency fall-through, and provides flush, fill level and almost flags.
module axi_buffer_rab_ft #(
    parameter int DATA_WIDTH      = 64,
    parameter int BUFFER_DEPTH    = 4,
    parameter int FALL_THROUGH    = 0,
    parameter int ALMOST_FULL_TH  = BUFFER_DEPTH - 1,
    parameter int ALMOST_EMPTY_TH = 1,
    localparam int PTR_W = (BUFFER_DEPTH > 2) ? $clog2(BUFFER_DEPTH) : 1,
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [CNT_W-1:0]      fill_level,
    output logic                  almost_full,
    output logic                  almost_empty
);

    // Handshake: a beat moves on an edge where valid and ready are both high on that side.
    // ready_out never looks at ready_in, so a full buffer turns away a push even while it pops.
    // flush forces both ready_out and valid_out low.

    logic [DATA_WIDTH-1:0] storage [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic ft_empty;
    logic bypass;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (cnt == CNT_W'(BUFFER_DEPTH));
    assign empty     = (cnt == '0);
    assign ft_empty  = (FALL_THROUGH != 0) && empty;
    assign ready_out = !full && !flush;
    assign valid_out = ft_empty ? (valid_in && !flush) : (!empty && !flush);

    always_comb begin
        data_out = '0;
        if (valid_out) begin
            data_out = ft_empty ? data_in : storage[rd_ptr];
        end
    end

    assign push   = valid_in && ready_out;
    assign pop    = valid_out && ready_in;
    // An empty fall-through buffer hands the beat straight on without touching storage.
    assign bypass = ft_empty && push && pop;

    always_ff @(posedge clk) begin
        if (push && !bypass) begin
            storage[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (!bypass) begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign fill_level   = cnt;
    assign almost_full  = (cnt >= CNT_W'(ALMOST_FULL_TH));
    assign almost_empty = (cnt <= CNT_W'(ALMOST_EMPTY_TH));

endmodule

// File: tb/tb_axi_buffer_rab_ft.sv
// Directed bench for axi_buffer_rab_ft: four instances cover depth 3, 5 and 4 in registered
// mode, plus depth 4 in fall-through mode.
module tb_axi_buffer_rab_ft;

    logic clk;
    logic rstn;

    // a: depth 3 registered, b: depth 5 registered, c: depth 4 fall-through, d: depth 4 registered
    logic       a_flush, a_vin, a_rin, a_rout, a_vout, a_af, a_ae;
    logic [7:0] a_din, a_dout;
    logic [1:0] a_fill;
    logic       b_flush, b_vin, b_rin, b_rout, b_vout, b_af, b_ae;
    logic [7:0] b_din, b_dout;
    logic [2:0] b_fill;
    logic       c_flush, c_vin, c_rin, c_rout, c_vout, c_af, c_ae;
    logic [7:0] c_din, c_dout;
    logic [2:0] c_fill;
    logic       d_flush, d_vin, d_rin, d_rout, d_vout, d_af, d_ae;
    logic [7:0] d_din, d_dout;
    logic [2:0] d_fill;

    int n_checks = 0;
    int n_pass   = 0;

    axi_buffer_rab_ft #(.DATA_WIDTH(8), .BUFFER_DEPTH(3), .FALL_THROUGH(0)) u_a (
        .clk(clk), .rstn(rstn), .flush(a_flush), .valid_in(a_vin), .data_in(a_din),
        .ready_out(a_rout), .data_out(a_dout), .valid_out(a_vout), .ready_in(a_rin),
        .fill_level(a_fill), .almost_full(a_af), .almost_empty(a_ae));

    axi_buffer_rab_ft #(.DATA_WIDTH(8), .BUFFER_DEPTH(5), .FALL_THROUGH(0)) u_b (
        .clk(clk), .rstn(rstn), .flush(b_flush), .valid_in(b_vin), .data_in(b_din),
        .ready_out(b_rout), .data_out(b_dout), .valid_out(b_vout), .ready_in(b_rin),
        .fill_level(b_fill), .almost_full(b_af), .almost_empty(b_ae));

    axi_buffer_rab_ft #(.DATA_WIDTH(8), .BUFFER_DEPTH(4), .FALL_THROUGH(1)) u_c (
        .clk(clk), .rstn(rstn), .flush(c_flush), .valid_in(c_vin), .data_in(c_din),
        .ready_out(c_rout), .data_out(c_dout), .valid_out(c_vout), .ready_in(c_rin),
        .fill_level(c_fill), .almost_full(c_af), .almost_empty(c_ae));

    axi_buffer_rab_ft #(.DATA_WIDTH(8), .BUFFER_DEPTH(4), .FALL_THROUGH(0)) u_d (
        .clk(clk), .rstn(rstn), .flush(d_flush), .valid_in(d_vin), .data_in(d_din),
        .ready_out(d_rout), .data_out(d_dout), .valid_out(d_vout), .ready_in(d_rin),
        .fill_level(d_fill), .almost_full(d_af), .almost_empty(d_ae));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (a_rout !== 1'b1) $display("FAIL reset_a_ready: got %b want 1", a_rout); else n_pass++;
        n_checks++; if (a_vout !== 1'b0) $display("FAIL reset_a_valid: got %b want 0", a_vout); else n_pass++;
        n_checks++; if (a_dout !== 8'h00) $display("FAIL reset_a_data: got %h want 00", a_dout); else n_pass++;
        n_checks++; if (a_fill !== 2'd0) $display("FAIL reset_a_fill: got %0d want 0", a_fill); else n_pass++;
        n_checks++; if (a_af !== 1'b0) $display("FAIL reset_a_af: got %b want 0", a_af); else n_pass++;
        n_checks++; if (a_ae !== 1'b1) $display("FAIL reset_a_ae: got %b want 1", a_ae); else n_pass++;
        n_checks++; if (c_vout !== 1'b0) $display("FAIL reset_c_valid: got %b want 0", c_vout); else n_pass++;
        n_checks++; if (d_fill !== 3'd0) $display("FAIL reset_d_fill: got %0d want 0", d_fill); else n_pass++;
        #10;
        rstn = 1'b1;
        step();
    endtask

    task automatic test_fill_drain_d3();
        logic [7:0] beats [3];
        beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
        a_rin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_vin = 1'b1; a_din = beats[i];
            step();
        end
        a_vin = 1'b0; a_din = 8'h00;
        #1;
        n_checks++; if (a_rout !== 1'b0) $display("FAIL d3_full_ready: got %b want 0", a_rout); else n_pass++;
        n_checks++; if (a_fill !== 2'd3) $display("FAIL d3_full_fill: got %0d want 3", a_fill); else n_pass++;
        n_checks++; if (a_af !== 1'b1) $display("FAIL d3_full_af: got %b want 1", a_af); else n_pass++;
        n_checks++; if (a_ae !== 1'b0) $display("FAIL d3_full_ae: got %b want 0", a_ae); else n_pass++;
        a_rin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (a_vout !== 1'b1) $display("FAIL d3_drain_valid%0d: got %b want 1", i, a_vout); else n_pass++;
            n_checks++; if (a_dout !== beats[i]) $display("FAIL d3_drain_data%0d: got %h want %h", i, a_dout, beats[i]); else n_pass++;
            step();
        end
        a_rin = 1'b0;
        #1;
        n_checks++; if (a_fill !== 2'd0) $display("FAIL d3_empty_fill: got %0d want 0", a_fill); else n_pass++;
        n_checks++; if (a_ae !== 1'b1) $display("FAIL d3_empty_ae: got %b want 1", a_ae); else n_pass++;
        n_checks++; if (a_vout !== 1'b0) $display("FAIL d3_empty_valid: got %b want 0", a_vout); else n_pass++;
    endtask

    task automatic test_streaming_d5();
        logic [7:0] exp_q[$];
        logic [7:0] exp;
        b_rin = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            if (k < 40) begin
                b_vin = 1'b1; b_din = 8'(k); exp_q.push_back(8'(k));
            end else begin
                b_vin = 1'b0; b_din = 8'h00;
            end
            #1;
            if (k == 0) begin
                n_checks++; if (b_vout !== 1'b0) $display("FAIL d5_first_cycle_valid: got %b want 0", b_vout); else n_pass++;
            end else begin
                exp = exp_q.pop_front();
                n_checks++; if (b_vout !== 1'b1) $display("FAIL d5_stream_valid%0d: got %b want 1", k, b_vout); else n_pass++;
                n_checks++; if (b_dout !== exp) $display("FAIL d5_stream_data%0d: got %h want %h", k, b_dout, exp); else n_pass++;
                n_checks++; if (b_fill !== 3'd1) $display("FAIL d5_stream_fill%0d: got %0d want 1", k, b_fill); else n_pass++;
            end
            step();
        end
        b_rin = 1'b0;
        #1;
        n_checks++; if (b_fill !== 3'd0) $display("FAIL d5_end_fill: got %0d want 0", b_fill); else n_pass++;
        n_checks++; if (b_vout !== 1'b0) $display("FAIL d5_end_valid: got %b want 0", b_vout); else n_pass++;
    endtask

    task automatic test_fall_through();
        c_vin = 1'b1; c_din = 8'h55; c_rin = 1'b1;
        #1;
        n_checks++; if (c_vout !== 1'b1) $display("FAIL ft_bypass_valid: got %b want 1", c_vout); else n_pass++;
        n_checks++; if (c_dout !== 8'h55) $display("FAIL ft_bypass_data: got %h want 55", c_dout); else n_pass++;
        step();
        c_vin = 1'b1; c_din = 8'h55; c_rin = 1'b0;
        #1;
        n_checks++; if (c_fill !== 3'd0) $display("FAIL ft_bypass_fill: got %0d want 0", c_fill); else n_pass++;
        step();
        c_vin = 1'b0; c_din = 8'h00;
        #1;
        n_checks++; if (c_fill !== 3'd1) $display("FAIL ft_store_fill: got %0d want 1", c_fill); else n_pass++;
        n_checks++; if (c_dout !== 8'h55) $display("FAIL ft_store_data: got %h want 55", c_dout); else n_pass++;
        c_rin = 1'b1;
        step();
        // queued beat must leave before the one offered alongside it
        c_rin = 1'b0; c_vin = 1'b1; c_din = 8'h11;
        step();
        c_vin = 1'b1; c_din = 8'h22; c_rin = 1'b1;
        #1;
        n_checks++; if (c_dout !== 8'h11) $display("FAIL ft_order_first: got %h want 11", c_dout); else n_pass++;
        step();
        c_vin = 1'b0; c_din = 8'h00;
        #1;
        n_checks++; if (c_dout !== 8'h22) $display("FAIL ft_order_second: got %h want 22", c_dout); else n_pass++;
        step();
        c_rin = 1'b0;
        #1;
        n_checks++; if (c_fill !== 3'd0) $display("FAIL ft_end_fill: got %0d want 0", c_fill); else n_pass++;
        n_checks++; if (c_vout !== 1'b0) $display("FAIL ft_end_valid: got %b want 0", c_vout); else n_pass++;
    endtask

    task automatic test_full_pop();
        d_rin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d_vin = 1'b1; d_din = 8'h41 + 8'(i);
            step();
        end
        d_vin = 1'b1; d_din = 8'h45; d_rin = 1'b1;
        #1;
        n_checks++; if (d_fill !== 3'd4) $display("FAIL fp_full_fill: got %0d want 4", d_fill); else n_pass++;
        n_checks++; if (d_rout !== 1'b0) $display("FAIL fp_full_ready: got %b want 0", d_rout); else n_pass++;
        n_checks++; if (d_af !== 1'b1) $display("FAIL fp_full_af: got %b want 1", d_af); else n_pass++;
        n_checks++; if (d_dout !== 8'h41) $display("FAIL fp_full_data: got %h want 41", d_dout); else n_pass++;
        step();
        d_rin = 1'b0;
        #1;
        n_checks++; if (d_fill !== 3'd3) $display("FAIL fp_after_pop_fill: got %0d want 3", d_fill); else n_pass++;
        n_checks++; if (d_rout !== 1'b1) $display("FAIL fp_after_pop_ready: got %b want 1", d_rout); else n_pass++;
        step();
        d_vin = 1'b0; d_din = 8'h00; d_rin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (d_dout !== 8'h42 + 8'(i)) $display("FAIL fp_drain%0d: got %h want %h", i, d_dout, 8'h42 + 8'(i)); else n_pass++;
            step();
        end
        d_rin = 1'b0;
        #1;
        n_checks++; if (d_fill !== 3'd0) $display("FAIL fp_end_fill: got %0d want 0", d_fill); else n_pass++;
    endtask

    task automatic test_flush();
        d_rin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d_vin = 1'b1; d_din = 8'h31 + 8'(i);
            step();
        end
        d_flush = 1'b1; d_vin = 1'b1; d_din = 8'h66; d_rin = 1'b1;
        #1;
        n_checks++; if (d_rout !== 1'b0) $display("FAIL flush_ready: got %b want 0", d_rout); else n_pass++;
        n_checks++; if (d_vout !== 1'b0) $display("FAIL flush_valid: got %b want 0", d_vout); else n_pass++;
        n_checks++; if (d_dout !== 8'h00) $display("FAIL flush_data: got %h want 00", d_dout); else n_pass++;
        step();
        d_flush = 1'b0; d_vin = 1'b0; d_rin = 1'b0;
        #1;
        n_checks++; if (d_fill !== 3'd0) $display("FAIL flush_after_fill: got %0d want 0", d_fill); else n_pass++;
        n_checks++; if (d_vout !== 1'b0) $display("FAIL flush_after_valid: got %b want 0", d_vout); else n_pass++;
        d_vin = 1'b1; d_din = 8'h77;
        step();
        d_vin = 1'b0; d_din = 8'h00; d_rin = 1'b1;
        #1;
        n_checks++; if (d_dout !== 8'h77) $display("FAIL flush_new_data: got %h want 77", d_dout); else n_pass++;
        n_checks++; if (d_fill !== 3'd1) $display("FAIL flush_new_fill: got %0d want 1", d_fill); else n_pass++;
        step();
        d_rin = 1'b0;
    endtask

    task automatic test_async_reset();
        d_rin = 1'b0;
        d_vin = 1'b1; d_din = 8'h21;
        step();
        d_din = 8'h22;
        step();
        d_vin = 1'b0; d_din = 8'h00;
        #1;
        n_checks++; if (d_fill !== 3'd2) $display("FAIL ar_pre_fill: got %0d want 2", d_fill); else n_pass++;
        #1;
        rstn = 1'b0;
        #1;
        n_checks++; if (d_fill !== 3'd0) $display("FAIL ar_fill: got %0d want 0", d_fill); else n_pass++;
        n_checks++; if (d_vout !== 1'b0) $display("FAIL ar_valid: got %b want 0", d_vout); else n_pass++;
        n_checks++; if (d_dout !== 8'h00) $display("FAIL ar_data: got %h want 00", d_dout); else n_pass++;
        n_checks++; if (d_rout !== 1'b1) $display("FAIL ar_ready: got %b want 1", d_rout); else n_pass++;
        n_checks++; if (d_ae !== 1'b1) $display("FAIL ar_ae: got %b want 1", d_ae); else n_pass++;
        #4;
        rstn = 1'b1;
        step();
        d_vin = 1'b1; d_din = 8'h99;
        step();
        d_vin = 1'b0; d_din = 8'h00; d_rin = 1'b1;
        #1;
        n_checks++; if (d_dout !== 8'h99) $display("FAIL ar_first_data: got %h want 99", d_dout); else n_pass++;
        n_checks++; if (d_fill !== 3'd1) $display("FAIL ar_first_fill: got %0d want 1", d_fill); else n_pass++;
        step();
        d_rin = 1'b0;
        #1;
        n_checks++; if (d_fill !== 3'd0) $display("FAIL ar_end_fill: got %0d want 0", d_fill); else n_pass++;
    endtask

    initial begin
        rstn = 1'b0;
        a_flush = 1'b0; a_vin = 1'b0; a_rin = 1'b0; a_din = 8'h00;
        b_flush = 1'b0; b_vin = 1'b0; b_rin = 1'b0; b_din = 8'h00;
        c_flush = 1'b0; c_vin = 1'b0; c_rin = 1'b0; c_din = 8'h00;
        d_flush = 1'b0; d_vin = 1'b0; d_rin = 1'b0; d_din = 8'h00;
        test_reset();
        test_fill_drain_d3();
        test_streaming_d5();
        test_fall_through();
        test_full_pop();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
